// File: rtl/mem_bus_adapter_pkg.sv
// Shared definitions for the MEM-stage to req/ack bus adapter.
//   mba_state_e          : adapter FSM state encodings (IDLE/REQ/DONE)
//   MBA_FAULT_RD_DEFAULT : load data returned when an access faults
//   mba_fault_cause_e    : fault cause codes, reserved for a future cause output
package mem_bus_adapter_pkg;

  typedef enum logic [1:0] {
    MBA_IDLE = 2'd0,
    MBA_REQ  = 2'd1,
    MBA_DONE = 2'd2
  } mba_state_e;

  localparam logic [31:0] MBA_FAULT_RD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MBA_FC_NONE     = 2'd0,
    MBA_FC_MISALIGN = 2'd1,
    MBA_FC_BUS_ERR  = 2'd2,
    MBA_FC_TIMEOUT  = 2'd3
  } mba_fault_cause_e;

endpackage

// File: rtl/mem_bus_adapter_timeout.sv
// Bus request timeout counter.
//   clk       in  system clock, rising edge
//   rst_n     in  synchronous reset, active-low
//   clear_i   in  force count to zero (has priority over enable_i)
//   enable_i  in  count one cycle
//   expired_o out high in the enabled cycle where the count equals TIMEOUT-1
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_adapter.sv
// Converts the single-cycle MEM-stage memory port into a req/ack bus access
// with variable latency, stalling the pipeline until the access completes and
// pulsing mem_fault on misaligned, errored or timed-out accesses.
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   mem_en                     MEM stage advance enable (releases DONE)
//   mem_ren/mem_wen            read/write request, sampled only in IDLE
//   mem_addr/mem_dout          byte address / store data
//   mem_din                    load data (registered)
//   mem_stall                  combinational pipeline hold
//   mem_fault                  1-cycle registered fault pulse
//   bus_req/bus_we/bus_addr/bus_wdata  registered bus request side
//   bus_ack/bus_err/bus_rdata  slave completion, error (qualified by ack), read data
module mem_bus_adapter
  import mem_bus_adapter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] FAULT_RD = MBA_FAULT_RD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       mem_din,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);

  mba_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              mem_fault_q, mem_fault_d;
  logic              stall_c;

  logic access;
  logic aligned;
  logic in_req;
  logic cnt_expired;

  assign access  = mem_ren | mem_wen;
  assign aligned = (mem_addr[1:0] == 2'b00);
  assign in_req  = (state_q == MBA_REQ);

  // Count is held at zero outside REQ so it always starts from 0 on entry.
  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (~in_req),
    .enable_i  (in_req),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_din_d   = mem_din_q;
    mem_fault_d = 1'b0;
    stall_c     = 1'b0;

    unique case (state_q)
      MBA_IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_c     = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wen;
            bus_addr_d  = mem_addr[ADDR_W+1:2];
            bus_wdata_d = mem_dout;
            // Simultaneous read and write: the write is performed and load data is zero.
            if (mem_ren && mem_wen) begin
              mem_din_d = '0;
            end
            state_d = MBA_REQ;
          end else begin
            mem_fault_d = 1'b1;
            mem_din_d   = FAULT_RD;
          end
        end
      end

      MBA_REQ: begin
        stall_c = 1'b1;
        // An ack in the final timeout cycle still completes the access normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = MBA_DONE;
          if (bus_err) begin
            mem_din_d   = FAULT_RD;
            mem_fault_d = 1'b1;
          end else if (!bus_we_q) begin
            mem_din_d = bus_rdata;
          end
        end else if (cnt_expired) begin
          bus_req_d   = 1'b0;
          mem_din_d   = FAULT_RD;
          mem_fault_d = 1'b1;
          state_d     = MBA_DONE;
        end
      end

      MBA_DONE: begin
        if (mem_en) begin
          state_d = MBA_IDLE;
        end
      end

      default: begin
        state_d   = MBA_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= MBA_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_din_q   <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_din_q   <= mem_din_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign mem_stall = rst_n & stall_c;
  assign mem_din   = mem_din_q;
  assign mem_fault = mem_fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Directed self-checking bench for mem_bus_adapter (TIMEOUT=8).
module tb_mem_bus_adapter;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_fault;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  int          st, rq, ft;
  logic        we0;
  logic [29:0] a0;
  logic [31:0] wd0;

  mem_bus_adapter #(
    .ADDR_W   (30),
    .TIMEOUT  (8),
    .FAULT_RD (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_en    (mem_en),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_fault (mem_fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts an access at negedge+1, plays a slave that acks on REQ cycle waits+1,
  // and observes 20 cycles with mem_en low. Leaves the adapter in DONE (or IDLE).
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input logic [31:0] rdata, input logic hold_req,
                           output int stalls, output int reqs, output int faults,
                           output logic we_o, output logic [29:0] addr_o,
                           output logic [31:0] wdata_o);
    stalls = 0; reqs = 0; faults = 0;
    we_o = 1'b0; addr_o = '0; wdata_o = '0;
    mem_en = 1'b0; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c == 1 && !hold_req) begin
        mem_ren = 1'b0; mem_wen = 1'b0;
        mem_addr = 32'hFFFF_FFF0; mem_dout = 32'h0BAD_0BAD;
      end
      if (mem_stall) stalls++;
      if (mem_fault) faults++;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          we_o = bus_we; addr_o = bus_addr; wdata_o = bus_wdata;
        end
        if (reqs == waits + 1) begin
          bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
        end
      end
      @(negedge clk); #1;
    end
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic finish_access();
    mem_ren = 1'b0; mem_wen = 1'b0; mem_en = 1'b1;
    @(negedge clk); #1;
    mem_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_en = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0;
    mem_addr = 32'h0000_0010; mem_dout = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus_req); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", mem_din); end
    n_cmp++; if (mem_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", mem_fault); end
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    mem_ren = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_read_zero_wait();
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL rd_stalls: got %0d want 2", st); end
    n_cmp++; if (rq !== 1) begin n_bad++; $display("FAIL rd_reqs: got %0d want 1", rq); end
    n_cmp++; if (a0 !== 30'h4) begin n_bad++; $display("FAIL rd_addr: got %h want 4", a0); end
    n_cmp++; if (we0 !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", we0); end
    n_cmp++; if (mem_din !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_din: got %h want 12345678", mem_din); end
    n_cmp++; if (ft !== 0) begin n_bad++; $display("FAIL rd_fault: got %0d want 0", ft); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL rd_done_stall: got %b want 0", mem_stall); end
    finish_access();
  endtask

  task automatic test_write_waits();
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 1'b0, 32'h7777_7777, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL wr_stalls: got %0d want 5", st); end
    n_cmp++; if (rq !== 4) begin n_bad++; $display("FAIL wr_reqs: got %0d want 4", rq); end
    n_cmp++; if (we0 !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", we0); end
    n_cmp++; if (wd0 !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wr_wdata: got %h want cafef00d", wd0); end
    n_cmp++; if (a0 !== 30'h8) begin n_bad++; $display("FAIL wr_addr: got %h want 8", a0); end
    n_cmp++; if (mem_din !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_din_kept: got %h want 12345678", mem_din); end
    n_cmp++; if (ft !== 0) begin n_bad++; $display("FAIL wr_fault: got %0d want 0", ft); end
    finish_access();
  endtask

  task automatic test_read_write_both();
    do_access(1'b1, 1'b1, 32'h0000_0030, 32'h0F0F_0F0F, 0, 1'b0, 32'h5555_5555, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (we0 !== 1'b1) begin n_bad++; $display("FAIL both_we: got %b want 1", we0); end
    n_cmp++; if (a0 !== 30'hC) begin n_bad++; $display("FAIL both_addr: got %h want c", a0); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL both_din: got %h want 0", mem_din); end
    finish_access();
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h0000_0006, 32'h0, 0, 1'b0, 32'h0, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (rq !== 0) begin n_bad++; $display("FAIL mis_reqs: got %0d want 0", rq); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL mis_stalls: got %0d want 0", st); end
    n_cmp++; if (ft !== 1) begin n_bad++; $display("FAIL mis_fault: got %0d want 1", ft); end
    n_cmp++; if (mem_din !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mis_din: got %h want ffffffff", mem_din); end
  endtask

  task automatic test_timeout();
    // Seed mem_din with a known read first so the fault value is a visible change.
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 1'b0, 32'h2468_ACE0, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (mem_din !== 32'h2468_ACE0) begin n_bad++; $display("FAIL to_seed_din: got %h want 2468ace0", mem_din); end
    finish_access();
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 100, 1'b0, 32'h0, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (rq !== 8) begin n_bad++; $display("FAIL to_reqs: got %0d want 8", rq); end
    n_cmp++; if (st !== 9) begin n_bad++; $display("FAIL to_stalls: got %0d want 9", st); end
    n_cmp++; if (ft !== 1) begin n_bad++; $display("FAIL to_fault: got %0d want 1", ft); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL to_req_end: got %b want 0", bus_req); end
    n_cmp++; if (mem_din !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_din: got %h want ffffffff", mem_din); end
    finish_access();
  endtask

  task automatic test_bus_err_hold_done();
    // Request inputs stay asserted through DONE: they must not start a second access.
    do_access(1'b0, 1'b1, 32'h0000_0080, 32'h1357_9BDF, 1, 1'b1, 32'h0, 1'b1, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (rq !== 2) begin n_bad++; $display("FAIL err_reqs: got %0d want 2", rq); end
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL err_stalls: got %0d want 3", st); end
    n_cmp++; if (ft !== 1) begin n_bad++; $display("FAIL err_fault: got %0d want 1", ft); end
    n_cmp++; if (mem_din !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL err_din: got %h want ffffffff", mem_din); end
    finish_access();
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL err_idle_stall: got %b want 0", mem_stall); end
  endtask

  task automatic test_stray_ack();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    n_cmp++; if (mem_din !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL stray_din: got %h want ffffffff", mem_din); end
    n_cmp++; if (mem_fault !== 1'b0) begin n_bad++; $display("FAIL stray_fault: got %b want 0", mem_fault); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL stray_req: got %b want 0", bus_req); end
  endtask

  task automatic test_reset_mid_access();
    mem_en = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0040;
    @(negedge clk); #1;
    mem_ren = 1'b0;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %b want 1", bus_req); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus_req); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL rst_din: got %h want 0", mem_din); end
    n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus_we); end
    n_cmp++; if (bus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus_wdata); end
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus_addr); end
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 32'hA5A5_0001, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (rq !== 1) begin n_bad++; $display("FAIL b2b0_reqs: got %0d want 1", rq); end
    n_cmp++; if (a0 !== 30'h40) begin n_bad++; $display("FAIL b2b0_addr: got %h want 40", a0); end
    n_cmp++; if (mem_din !== 32'hA5A5_0001) begin n_bad++; $display("FAIL b2b0_din: got %h want a5a50001", mem_din); end
    finish_access();
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 1'b0, 32'h5A5A_0002, 1'b0, st, rq, ft, we0, a0, wd0);
    n_cmp++; if (rq !== 2) begin n_bad++; $display("FAIL b2b1_req_cycles: got %0d want 2", rq); end
    n_cmp++; if (a0 !== 30'h41) begin n_bad++; $display("FAIL b2b1_addr: got %h want 41", a0); end
    n_cmp++; if (mem_din !== 32'h5A5A_0002) begin n_bad++; $display("FAIL b2b1_din: got %h want 5a5a0002", mem_din); end
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL b2b1_stalls: got %0d want 3", st); end
    finish_access();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_read_write_both();
    test_misaligned();
    test_timeout();
    test_bus_err_hold_done();
    test_stray_ack();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
